// File: rtl/prime_sequencer_pkg.sv
// Shared definitions for the prime sequencer: state encoding, value width
// and the debug view of the sequencer's internal registers.
package prime_sequencer_pkg;

    localparam int VAL_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        EMIT = 2'd2,
        FIN  = 2'd3
    } state_t;

    // Snapshot of the sequencer internals, exported for observation.
    typedef struct packed {
        state_t             state;
        logic [VAL_W-1:0]   cur;
        logic [VAL_W-1:0]   lo_q;
        logic [VAL_W-1:0]   hi_q;
    } dbg_t;

endpackage

// File: rtl/prime_sequencer_is_prime.sv
// Combinational prime detector for a 3-bit value {c,b,a}.
// Primes in 0..7 are 2, 3, 5 and 7.
module is_prime_behavioral (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic p
);

    // Decode the 3-bit value into the prime flag.
    always_comb begin
        p = 1'b0;
        case ({c, b, a})
            3'd2, 3'd3, 3'd5, 3'd7: p = 1'b1;
            default:                p = 1'b0;
        endcase
    end

endmodule

// File: rtl/prime_sequencer.sv
// Walks the candidate range [lo, hi] one value per cycle and streams every
// prime out over a valid/ready handshake.
//
// Handshake: out_value is offered while out_valid=1 and is held stable until
// a rising edge where out_valid && out_ready; that edge is the transfer.
// out_ready is ignored while out_valid=0.
module prime_sequencer
    import prime_sequencer_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [VAL_W-1:0] lo,
    input  logic [VAL_W-1:0] hi,
    output logic [VAL_W-1:0] out_value,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] prime_count,
    output dbg_t             dbg
);

    state_t           state, state_n;
    logic [VAL_W-1:0] cur, cur_n;
    logic [VAL_W-1:0] lo_q, lo_q_n;
    logic [VAL_W-1:0] hi_q, hi_q_n;
    logic [VAL_W-1:0] value_n;
    logic [CNT_W-1:0] count_n;
    logic             cur_is_prime;

    is_prime_behavioral u_is_prime (
        .a (cur[0]),
        .b (cur[1]),
        .c (cur[2]),
        .p (cur_is_prime)
    );

    // Register the FSM state and its datapath; reset overrides everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cur         <= '0;
            lo_q        <= '0;
            hi_q        <= '0;
            out_value   <= '0;
            prime_count <= '0;
        end else begin
            state       <= state_n;
            cur         <= cur_n;
            lo_q        <= lo_q_n;
            hi_q        <= hi_q_n;
            out_value   <= value_n;
            prime_count <= count_n;
        end
    end

    // Next-state and datapath update. cur is compared with hi_q before any
    // increment, so a scan ending at 7 never wraps back to 0.
    always_comb begin
        state_n = state;
        cur_n   = cur;
        lo_q_n  = lo_q;
        hi_q_n  = hi_q;
        value_n = out_value;
        count_n = prime_count;
        case (state)
            IDLE: begin
                if (start) begin
                    lo_q_n  = lo;
                    hi_q_n  = hi;
                    cur_n   = lo;
                    count_n = '0;
                    state_n = (lo <= hi) ? SCAN : FIN;
                end
            end
            SCAN: begin
                if (cur_is_prime) begin
                    value_n = cur;
                    state_n = EMIT;
                end else if (cur == hi_q) begin
                    state_n = FIN;
                end else begin
                    cur_n = cur + VAL_W'(1);
                end
            end
            EMIT: begin
                if (out_ready) begin
                    count_n = prime_count + CNT_W'(1);
                    if (cur == hi_q) begin
                        state_n = FIN;
                    end else begin
                        cur_n   = cur + VAL_W'(1);
                        state_n = SCAN;
                    end
                end
            end
            FIN: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Status outputs decode directly from the registered state.
    always_comb begin
        out_valid  = (state == EMIT);
        busy       = (state != IDLE);
        done       = (state == FIN);
        dbg.state  = state;
        dbg.cur    = cur;
        dbg.lo_q   = lo_q;
        dbg.hi_q   = hi_q;
    end

endmodule
